f32_addsub_issue: RTL and testbench

- Upstream issue stage for F32AdderSubtractor.
- Queues {A, B, OP} requests behind a valid/ready handshake and classifies each head operand pair.
- Special cases (NaN/Inf/zero) are resolved locally. Other pairs are driven to the combinational adder through registered ports; the stage waits a fixed settle time, then captures R/UNDERFLOW/OVERFLOW into a result register behind a second valid/ready handshake.

---
 rtl/f32_pkg.sv | 29 ++
 rtl/f32_classify.sv | 26 ++
 rtl/f32_addsub_issue.sv | 194 +++++++++++++++++++
 tb/tb_f32_addsub_issue.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/f32_pkg.sv
// Shared IEEE-754 single field layout, issue-stage types and result flag positions.
package f32_pkg;

    localparam int unsigned F32_W    = 32;
    localparam int unsigned SIGN_BIT = 31;
    localparam int unsigned EXP_MSB  = 30;
    localparam int unsigned EXP_LSB  = 23;
    localparam int unsigned EXP_W    = 8;
    localparam int unsigned MAN_MSB  = 22;
    localparam int unsigned MAN_W    = 23;

    localparam logic [F32_W-1:0] QNAN = 32'h7FC0_0000;

    localparam int unsigned FLAG_W         = 4;
    localparam int unsigned FLAG_INVALID   = 3;
    localparam int unsigned FLAG_SPECIAL   = 2;
    localparam int unsigned FLAG_OVERFLOW  = 1;
    localparam int unsigned FLAG_UNDERFLOW = 0;

    typedef enum logic [2:0] {ZERO, SUBNORMAL, NORMAL, INF, NAN} f32_class_t;
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} issue_state_t;

    typedef struct packed {
        logic [F32_W-1:0] a;
        logic [F32_W-1:0] b;
        logic             op;
    } issue_req_t;

endpackage

// File: rtl/f32_classify.sv
// Combinational IEEE-754 single operand classifier.
module f32_classify
    import f32_pkg::*;
(
    input  logic [F32_W-1:0] in_val,
    output f32_class_t       cls_c
);

    logic [EXP_W-1:0] exp_v;
    logic [MAN_W-1:0] man_v;
    logic             unused_sign;

    assign exp_v       = in_val[EXP_MSB:EXP_LSB];
    assign man_v       = in_val[MAN_MSB:0];
    assign unused_sign = in_val[SIGN_BIT];

    always_comb begin
        cls_c = NORMAL;
        if (exp_v == '1) begin
            cls_c = (man_v != '0) ? NAN : INF;
        end else if (exp_v == '0) begin
            cls_c = (man_v != '0) ? SUBNORMAL : ZERO;
        end
    end

endmodule

// File: rtl/f32_addsub_issue.sv
// Issue stage for the F32 adder: request FIFO, local special-case resolution, settle-timed capture.
// Optional: F32_SUBNORMAL_FLUSH_EN flushes subnormal operands to signed zero before classification.
module f32_addsub_issue
    import f32_pkg::*;
#(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [F32_W-1:0]         IN_A,
    input  logic [F32_W-1:0]         IN_B,
    input  logic                     IN_OP,
    output logic [F32_W-1:0]         ADD_A,
    output logic [F32_W-1:0]         ADD_B,
    output logic                     ADD_OP,
    input  logic [F32_W-1:0]         ADD_R,
    input  logic                     ADD_UNDERFLOW,
    input  logic                     ADD_OVERFLOW,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [F32_W-1:0]         OUT_R,
    output logic [FLAG_W-1:0]        OUT_FLAGS,
    output logic [$clog2(DEPTH):0]   COUNT
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);

    issue_req_t         mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               in_ready_q, in_ready_d;
    issue_state_t       state_q, state_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [F32_W-1:0]   add_a_q, add_a_d, add_b_q, add_b_d;
    logic               add_op_q, add_op_d;
    logic               out_valid_q, out_valid_d;
    logic [F32_W-1:0]   out_r_q, out_r_d;
    logic [FLAG_W-1:0]  out_flags_q, out_flags_d;

    logic               push, pop;
    issue_req_t         head;
    f32_class_t         cls_a, cls_b;
    logic               a_flush, b_flush, a_zero, b_zero, sa, eb;
    logic [F32_W-1:0]   a_val, b_val, spec_r;
    logic [FLAG_W-1:0]  spec_flags;
    logic               spec_hit;

    assign push = IN_VALID && in_ready_q;
    assign pop  = (state_q == IDLE) && (count_q != '0);
    assign head = mem_q[rd_ptr_q];

    f32_classify u_cls_a (.in_val(head.a), .cls_c(cls_a));
    f32_classify u_cls_b (.in_val(head.b), .cls_c(cls_b));

    // Resolve NaN/Inf/zero pairs locally; eb is B's sign after applying the operation.
    always_comb begin
        a_flush = 1'b0;
        b_flush = 1'b0;
`ifdef F32_SUBNORMAL_FLUSH_EN
        a_flush = (cls_a == SUBNORMAL);
        b_flush = (cls_b == SUBNORMAL);
`endif
        a_val      = a_flush ? {head.a[SIGN_BIT], (F32_W-1)'(0)} : head.a;
        b_val      = b_flush ? {head.b[SIGN_BIT], (F32_W-1)'(0)} : head.b;
        a_zero     = (cls_a == ZERO) || a_flush;
        b_zero     = (cls_b == ZERO) || b_flush;
        sa         = head.a[SIGN_BIT];
        eb         = head.b[SIGN_BIT] ^ head.op;
        spec_hit   = 1'b1;
        spec_r     = '0;
        spec_flags = '0;
        if ((cls_a == NAN) || (cls_b == NAN) || ((cls_a == INF) && (cls_b == INF) && (sa != eb))) begin
            spec_r                     = QNAN;
            spec_flags[FLAG_INVALID]   = 1'b1;
        end else if (cls_a == INF) begin
            spec_r = {sa, a_val[EXP_MSB:0]};
        end else if (cls_b == INF) begin
            spec_r = {eb, b_val[EXP_MSB:0]};
        end else if (a_zero && b_zero) begin
            spec_r = {sa & eb, (F32_W-1)'(0)};
        end else if (a_zero) begin
            spec_r = {eb, b_val[EXP_MSB:0]};
        end else if (b_zero) begin
            spec_r = a_val;
        end else begin
            spec_hit = 1'b0;
        end
        spec_flags[FLAG_SPECIAL]   = spec_hit;
        spec_flags[FLAG_UNDERFLOW] = spec_hit && (a_flush || b_flush);
    end

    // FIFO bookkeeping and the IDLE/SETTLE/HOLD sequencer.
    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        in_ready_d  = (count_d != CNT_W'(DEPTH));
        state_d     = state_q;
        settle_d    = settle_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_op_d    = add_op_q;
        out_valid_d = out_valid_q;
        out_r_d     = out_r_q;
        out_flags_d = out_flags_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    if (spec_hit) begin
                        out_r_d     = spec_r;
                        out_flags_d = spec_flags;
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end else begin
                        add_a_d  = a_val;
                        add_b_d  = b_val;
                        add_op_d = head.op;
                        settle_d = SET_W'(SETTLE_CYCLES - 1);
                        state_d  = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (settle_q != '0) begin
                    settle_d = settle_q - SET_W'(1);
                end else begin
                    out_r_d     = ADD_R;
                    out_flags_d = {1'b0, 1'b0, ADD_OVERFLOW, ADD_UNDERFLOW};
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (OUT_READY) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
            settle_q    <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_op_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            out_flags_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            state_q     <= state_d;
            settle_q    <= settle_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_op_q    <= add_op_d;
            out_valid_q <= out_valid_d;
            out_r_q     <= out_r_d;
            out_flags_q <= out_flags_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {IN_A, IN_B, IN_OP};
        end
    end

    assign IN_READY  = in_ready_q;
    assign COUNT     = count_q;
    assign ADD_A     = add_a_q;
    assign ADD_B     = add_b_q;
    assign ADD_OP    = add_op_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_R     = out_r_q;
    assign OUT_FLAGS = out_flags_q;

endmodule

// File: tb/tb_f32_addsub_issue.sv
// Directed self-checking bench for f32_addsub_issue (DEPTH=4, SETTLE_CYCLES=2) with a table-driven adder stand-in.
module tb_f32_addsub_issue;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] IN_A, IN_B;
    logic        IN_OP;
    logic [31:0] ADD_A, ADD_B;
    logic        ADD_OP;
    logic [31:0] ADD_R;
    logic        ADD_UNDERFLOW, ADD_OVERFLOW;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] OUT_R;
    logic [3:0]  OUT_FLAGS;
    logic [2:0]  COUNT;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    f32_addsub_issue #(.DEPTH(4), .SETTLE_CYCLES(2)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_A(IN_A), .IN_B(IN_B), .IN_OP(IN_OP),
        .ADD_A(ADD_A), .ADD_B(ADD_B), .ADD_OP(ADD_OP),
        .ADD_R(ADD_R), .ADD_UNDERFLOW(ADD_UNDERFLOW), .ADD_OVERFLOW(ADD_OVERFLOW),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_R(OUT_R),
        .OUT_FLAGS(OUT_FLAGS), .COUNT(COUNT)
    );

    // Adder stand-in: known sums only, anything else reads back as a marker value.
    always_comb begin
        ADD_R         = 32'hDEAD_BEEF;
        ADD_OVERFLOW  = 1'b0;
        ADD_UNDERFLOW = 1'b0;
        case ({ADD_A, ADD_B, ADD_OP})
            {32'h3F80_0000, 32'h4000_0000, 1'b0}: ADD_R = 32'h4040_0000;
            {32'h4040_0000, 32'h3F80_0000, 1'b1}: ADD_R = 32'h4000_0000;
            {32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0}: begin ADD_R = 32'h7F80_0000; ADD_OVERFLOW = 1'b1; end
            {32'h0000_0001, 32'h3F80_0000, 1'b0}: ADD_R = 32'h3F80_0000;
            {32'h40A0_0000, 32'h3F80_0000, 1'b0}: ADD_R = 32'h40C0_0000;
            default: ;
        endcase
    end

    // Drive one request into an empty, idle stage and accept its result; lat counts cycles after the pop cycle.
    task automatic do_txn(input logic [31:0] a, input logic [31:0] b, input logic op,
                          output logic [31:0] r, output logic [3:0] f, output int lat);
        int k;
        IN_VALID = 1'b1; IN_A = a; IN_B = b; IN_OP = op;
        @(negedge CLK);
        IN_VALID = 1'b0;
        k = 1;
        while (OUT_VALID !== 1'b1 && k < 40) begin
            @(negedge CLK);
            k++;
        end
        lat = (OUT_VALID === 1'b1) ? k - 1 : -1;
        r = OUT_R;
        f = OUT_FLAGS;
        OUT_READY = 1'b1;
        @(negedge CLK);
        OUT_READY = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if ({COUNT, IN_READY, OUT_VALID} !== 5'b000_1_0) begin failures++; $display("FAIL reset_ctrl got count=%0d rdy=%b vld=%b exp 0/1/0", COUNT, IN_READY, OUT_VALID); end
        checks++; if ({OUT_R, OUT_FLAGS} !== 36'h0) begin failures++; $display("FAIL reset_out got r=%h f=%b exp 0", OUT_R, OUT_FLAGS); end
        checks++; if ({ADD_A, ADD_B, ADD_OP} !== 65'h0) begin failures++; $display("FAIL reset_add got %h %h %b exp 0", ADD_A, ADD_B, ADD_OP); end
        RST = 1'b0;
        @(negedge CLK);
        checks++; if (COUNT !== 3'd0 || IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin failures++; $display("FAIL post_reset got count=%0d rdy=%b vld=%b", COUNT, IN_READY, OUT_VALID); end
    endtask

    task automatic test_normal();
        logic [31:0] r; logic [3:0] f; int lat;
        do_txn(32'h3F80_0000, 32'h4000_0000, 1'b0, r, f, lat);
        checks++; if (r !== 32'h4040_0000 || f !== 4'b0000) begin failures++; $display("FAIL add_1p2 got r=%h f=%b exp 40400000/0000", r, f); end
        checks++; if (lat !== 3) begin failures++; $display("FAIL add_latency got %0d exp 3", lat); end
        checks++; if (ADD_A !== 32'h3F80_0000 || ADD_B !== 32'h4000_0000 || ADD_OP !== 1'b0) begin failures++; $display("FAIL add_ports got %h %h %b", ADD_A, ADD_B, ADD_OP); end
        do_txn(32'h4040_0000, 32'h3F80_0000, 1'b1, r, f, lat);
        checks++; if (r !== 32'h4000_0000 || f !== 4'b0000 || lat !== 3) begin failures++; $display("FAIL sub_3m1 got r=%h f=%b lat=%0d exp 40000000/0000/3", r, f, lat); end
        checks++; if (ADD_OP !== 1'b1) begin failures++; $display("FAIL sub_op got %b exp 1", ADD_OP); end
        do_txn(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, r, f, lat);
        checks++; if (r !== 32'h7F80_0000 || f !== 4'b0010) begin failures++; $display("FAIL overflow got r=%h f=%b exp 7f800000/0010", r, f); end
    endtask

    task automatic test_special();
        logic [31:0] r; logic [3:0] f; int lat;
        do_txn(32'h7F80_0000, 32'h7F80_0000, 1'b1, r, f, lat);
        checks++; if (r !== 32'h7FC0_0000 || f !== 4'b1100) begin failures++; $display("FAIL inf_minus_inf got r=%h f=%b exp 7fc00000/1100", r, f); end
        checks++; if (lat !== 1) begin failures++; $display("FAIL special_latency got %0d exp 1", lat); end
        checks++; if (ADD_A !== 32'h7F7F_FFFF || ADD_B !== 32'h7F7F_FFFF || ADD_OP !== 1'b0) begin failures++; $display("FAIL special_add_hold got %h %h %b", ADD_A, ADD_B, ADD_OP); end
        do_txn(32'h7FC0_0001, 32'h3F80_0000, 1'b0, r, f, lat);
        checks++; if (r !== 32'h7FC0_0000 || f !== 4'b1100) begin failures++; $display("FAIL nan_in got r=%h f=%b exp 7fc00000/1100", r, f); end
        do_txn(32'h3F80_0000, 32'hFF80_0000, 1'b1, r, f, lat);
        checks++; if (r !== 32'h7F80_0000 || f !== 4'b0100) begin failures++; $display("FAIL minus_neg_inf got r=%h f=%b exp 7f800000/0100", r, f); end
        do_txn(32'h7F80_0000, 32'h7F80_0000, 1'b0, r, f, lat);
        checks++; if (r !== 32'h7F80_0000 || f !== 4'b0100) begin failures++; $display("FAIL inf_plus_inf got r=%h f=%b exp 7f800000/0100", r, f); end
    endtask

    task automatic test_zero();
        logic [31:0] r; logic [3:0] f; int lat;
        do_txn(32'h0000_0000, 32'h40A0_0000, 1'b1, r, f, lat);
        checks++; if (r !== 32'hC0A0_0000 || f !== 4'b0100 || lat !== 1) begin failures++; $display("FAIL zero_minus_b got r=%h f=%b lat=%0d exp c0a00000/0100/1", r, f, lat); end
        do_txn(32'h8000_0000, 32'h8000_0000, 1'b0, r, f, lat);
        checks++; if (r !== 32'h8000_0000 || f !== 4'b0100) begin failures++; $display("FAIL negz_plus_negz got r=%h f=%b exp 80000000/0100", r, f); end
        do_txn(32'h8000_0000, 32'h0000_0000, 1'b0, r, f, lat);
        checks++; if (r !== 32'h0000_0000 || f !== 4'b0100) begin failures++; $display("FAIL negz_plus_posz got r=%h f=%b exp 00000000/0100", r, f); end
        do_txn(32'hC120_0000, 32'h8000_0000, 1'b1, r, f, lat);
        checks++; if (r !== 32'hC120_0000 || f !== 4'b0100) begin failures++; $display("FAIL a_minus_zero got r=%h f=%b exp c1200000/0100", r, f); end
    endtask

    task automatic test_subnormal();
        logic [31:0] r; logic [3:0] f; int lat;
        do_txn(32'h0000_0001, 32'h3F80_0000, 1'b0, r, f, lat);
`ifdef F32_SUBNORMAL_FLUSH_EN
        checks++; if (r !== 32'h3F80_0000 || f !== 4'b0101 || lat !== 1) begin failures++; $display("FAIL subn_flush got r=%h f=%b lat=%0d exp 3f800000/0101/1", r, f, lat); end
        checks++; if (ADD_A !== 32'h7F7F_FFFF) begin failures++; $display("FAIL subn_no_issue got ADD_A=%h exp 7f7fffff", ADD_A); end
`else
        checks++; if (r !== 32'h3F80_0000 || f !== 4'b0000 || lat !== 3) begin failures++; $display("FAIL subn_fwd got r=%h f=%b lat=%0d exp 3f800000/0000/3", r, f, lat); end
        checks++; if (ADD_A !== 32'h0000_0001 || ADD_B !== 32'h3F80_0000) begin failures++; $display("FAIL subn_ports got %h %h exp 00000001/3f800000", ADD_A, ADD_B); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [6];
        logic [31:0] vb [6];
        logic        vo [6];
        logic [31:0] exp_r [6];
        logic [2:0]  exp_cnt [5];
        int          accepted, n, cyc;
        logic        pending, will_push;
        exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
        va[0] = 32'h3F80_0000; vb[0] = 32'h4000_0000; vo[0] = 1'b0; exp_r[0] = 32'h4040_0000;
        for (int i = 1; i < 6; i++) begin
            va[i] = 32'h0;
            vb[i] = 32'h4000_0000 | (32'(i) << 20);
            vo[i] = 1'(i & 1);
            exp_r[i] = vo[i] ? (vb[i] ^ 32'h8000_0000) : vb[i];
        end
        OUT_READY = 1'b0;
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            IN_VALID = 1'b1; IN_A = va[i]; IN_B = vb[i]; IN_OP = vo[i];
            if (IN_READY !== 1'b1) break;
            @(negedge CLK);
            checks++; if (COUNT !== exp_cnt[i]) begin failures++; $display("FAIL b2b_count%0d got %0d exp %0d", i, COUNT, exp_cnt[i]); end
            accepted++;
        end
        checks++; if (accepted !== 5 || IN_READY !== 1'b0) begin failures++; $display("FAIL full_accept got acc=%0d rdy=%b exp 5/0", accepted, IN_READY); end
        repeat (3) @(negedge CLK);
        checks++; if (COUNT !== 3'd4 || IN_READY !== 1'b0) begin failures++; $display("FAIL full_hold got count=%0d rdy=%b exp 4/0", COUNT, IN_READY); end
        OUT_READY = 1'b1;
        n = 0; cyc = 0; pending = 1'b1;
        while (n < 6 && cyc < 200) begin
            if (OUT_VALID === 1'b1) begin
                checks++; if (OUT_R !== exp_r[n]) begin failures++; $display("FAIL order%0d got %h exp %h", n, OUT_R, exp_r[n]); end
                n++;
            end
            will_push = pending && (IN_READY === 1'b1);
            @(negedge CLK);
            cyc++;
            if (will_push) begin IN_VALID = 1'b0; pending = 1'b0; end
        end
        IN_VALID = 1'b0;
        checks++; if (n !== 6 || COUNT !== 3'd0) begin failures++; $display("FAIL drain got results=%0d count=%0d exp 6/0", n, COUNT); end
        OUT_READY = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset_midflight();
        logic [31:0] va [5];
        int stale;
        va = '{32'h0, 32'h40A0_0000, 32'h0, 32'h0, 32'h0};
        OUT_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            IN_VALID = 1'b1; IN_A = va[i]; IN_OP = 1'b0;
            IN_B = (i == 0) ? 32'h4040_0000 : (i == 1) ? 32'h3F80_0000 : 32'h4100_0000;
            @(negedge CLK);
        end
        IN_VALID = 1'b0;
        checks++; if (COUNT !== 3'd4 || OUT_VALID !== 1'b1 || OUT_R !== 32'h4040_0000) begin failures++; $display("FAIL prefill got count=%0d vld=%b r=%h exp 4/1/40400000", COUNT, OUT_VALID, OUT_R); end
        OUT_READY = 1'b1;
        @(negedge CLK);
        OUT_READY = 1'b0;
        @(negedge CLK);
        checks++; if (COUNT !== 3'd3 || OUT_VALID !== 1'b0 || ADD_A !== 32'h40A0_0000) begin failures++; $display("FAIL in_settle got count=%0d vld=%b add_a=%h exp 3/0/40a00000", COUNT, OUT_VALID, ADD_A); end
        #2 RST = 1'b1;
        #1;
        checks++; if (COUNT !== 3'd0 || OUT_VALID !== 1'b0 || IN_READY !== 1'b1 || ADD_A !== 32'h0) begin failures++; $display("FAIL async_reset got count=%0d vld=%b rdy=%b add_a=%h", COUNT, OUT_VALID, IN_READY, ADD_A); end
        @(negedge CLK);
        RST = 1'b0;
        OUT_READY = 1'b1;
        stale = 0;
        repeat (8) begin
            @(negedge CLK);
            if (OUT_VALID === 1'b1) stale++;
        end
        checks++; if (stale !== 0 || COUNT !== 3'd0) begin failures++; $display("FAIL stale_after_reset got valid_cycles=%0d count=%0d exp 0/0", stale, COUNT); end
        OUT_READY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; IN_VALID = 1'b0; IN_A = '0; IN_B = '0; IN_OP = 1'b0; OUT_READY = 1'b0;
        repeat (2) @(negedge CLK);
        test_reset();
        test_normal();
        test_special();
        test_zero();
        test_subnormal();
        test_back_to_back();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
